// File: rtl/resp_misr.sv
// Response compactor: folds a DUT output bus into a Galois MISR signature over a
// programmed number of valid samples, then compares it with a latched golden word.
module resp_misr #(
    parameter int                 WIDTH = 12,
    parameter int                 CNT_W = 16,
    parameter logic [WIDTH-1:0]   POLY  = 12'h053,
    parameter logic [WIDTH-1:0]   SEED  = 12'h000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [WIDTH-1:0] expect_sig,
    input  logic [WIDTH-1:0] in_y,
    input  logic             in_valid,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sig,
    output logic             match,
    output logic [CNT_W-1:0] count,
    output logic [1:0]       dbg_state
);

    // Handshake: start is accepted only in IDLE/DONE; in_valid folds in_y only in RUN.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sig_q,   sig_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] len_q,   len_d;
    logic [WIDTH-1:0] exp_q,   exp_d;
    logic [WIDTH-1:0] fold;
    logic             last_sample;

    assign fold        = ({sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0)) ^ in_y;
    // len_q is never zero in RUN, so the subtraction cannot underflow there.
    assign last_sample = (count_q == len_q - 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sig_q   <= SEED;
            count_q <= '0;
            len_q   <= '0;
            exp_q   <= '0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            count_q <= count_d;
            len_q   <= len_d;
            exp_q   <= exp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        count_d = count_q;
        len_d   = len_q;
        exp_d   = exp_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    sig_d   = SEED;
                    count_d = '0;
                    len_d   = len;
                    exp_d   = expect_sig;
                    state_d = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (in_valid) begin
                    sig_d   = fold;
                    count_d = count_q + 1'b1;
                    if (last_sample) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign sig       = sig_q;
    assign count     = count_q;
    assign match     = done && (sig_q == exp_q);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_resp_misr.sv
// Bench for resp_misr: directed cases plus random captures, checked against a
// scoreboard of expected signature/match/count filled when stimulus is driven.
module tb_resp_misr;
    localparam int W  = 12;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] len;
    logic [W-1:0]  expect_sig;
    logic [W-1:0]  in_y;
    logic          in_valid;
    logic          busy;
    logic          done;
    logic [W-1:0]  sig;
    logic          match;
    logic [CW-1:0] count;
    logic [1:0]    dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0]  exp_q[$];
    logic          exp_match_q[$];
    logic [CW-1:0] exp_count_q[$];

    resp_misr dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .expect_sig(expect_sig),
        .in_y(in_y), .in_valid(in_valid), .busy(busy), .done(done), .sig(sig),
        .match(match), .count(count), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [W-1:0] fold(input logic [W-1:0] s, input logic [W-1:0] y);
        return ({s[W-2:0], 1'b0} ^ (s[W-1] ? 12'h053 : 12'h000)) ^ y;
    endfunction

    // Drivers: inputs change on the falling edge, outputs are sampled there too.
    task automatic do_start(input logic [CW-1:0] l, input logic [W-1:0] e);
        @(negedge clk);
        start = 1'b1; len = l; expect_sig = e;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] y, input logic v, input logic s);
        in_y = y; in_valid = v; start = s;
        @(negedge clk);
        in_valid = 1'b0; start = 1'b0;
    endtask

    task automatic push_exp(input logic [W-1:0] s, input logic [W-1:0] e, input logic [CW-1:0] c);
        exp_q.push_back(s);
        exp_match_q.push_back(s == e);
        exp_count_q.push_back(c);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            void'(exp_q.pop_front()); void'(exp_match_q.pop_front()); void'(exp_count_q.pop_front());
        end else begin
            check({tag, "_sig"},   32'(sig),   32'(exp_q.pop_front()));
            check({tag, "_match"}, 32'(match), 32'(exp_match_q.pop_front()));
            check({tag, "_count"}, 32'(count), 32'(exp_count_q.pop_front()));
            check({tag, "_state"}, 32'(dbg_state), 32'd2);
        end
    endtask

    task automatic rand_capture(input int idx);
        logic [W-1:0] ys[$];
        logic [W-1:0] m;
        logic [W-1:0] e;
        int           l;
        l = $urandom_range(1, 12);
        m = 12'h000;
        for (int i = 0; i < l; i++) begin
            ys.push_back(W'($urandom_range(0, 4095)));
            m = fold(m, ys[i]);
        end
        e = ($urandom_range(0, 1) == 1) ? m : W'($urandom_range(0, 4095));
        do_start(CW'(l), e);
        push_exp(m, e, CW'(l));
        for (int i = 0; i < l; i++) begin
            while ($urandom_range(0, 2) == 0) send(W'($urandom_range(0, 4095)), 1'b0, 1'b0);
            send(ys[i], 1'b1, 1'b0);
        end
        wait_done($sformatf("rand%0d", idx));
    endtask

    initial begin
        logic seen_done;
        rst = 1'b1; start = 1'b0; len = '0; expect_sig = '0; in_y = '0; in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sig", 32'(sig), 32'h000);
        check("rst_count", 32'(count), 32'd0);
        check("rst_match", 32'(match), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;

        // Reset mid-RUN abandons the capture
        do_start(16'd5, 12'h000);
        send(12'h123, 1'b1, 1'b0);
        send(12'h456, 1'b1, 1'b0);
        check("midrun_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rstrun_busy", 32'(busy), 32'd0);
        check("rstrun_done", 32'(done), 32'd0);
        check("rstrun_sig", 32'(sig), 32'h000);
        check("rstrun_count", 32'(count), 32'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send(12'hfff, 1'b1, 1'b0);
            seen_done |= done;
        end
        check("rstrun_nodone", 32'(seen_done), 32'd0);

        // Single sample
        do_start(16'd1, 12'h0a5);
        push_exp(12'h0a5, 12'h0a5, 16'd1);
        send(12'h0a5, 1'b1, 1'b0);
        check("single_done_next", 32'(done), 32'd1);
        wait_done("single");

        // Feedback path through the top bit
        do_start(16'd2, 12'h054);
        push_exp(12'h053, 12'h054, 16'd2);
        send(12'h800, 1'b1, 1'b0);
        send(12'h000, 1'b1, 1'b0);
        wait_done("feedback");

        // Valid gaps keep RUN and hold sig/count
        do_start(16'd2, 12'h053);
        push_exp(12'h053, 12'h053, 16'd2);
        check("gap_busy0", 32'(busy), 32'd1);
        send(12'h800, 1'b1, 1'b0);
        check("gap_busy1", 32'(busy), 32'd1);
        send(12'h3c3, 1'b0, 1'b0);
        check("gap_busy2", 32'(busy), 32'd1);
        check("gap_hold_sig", 32'(sig), 32'h800);
        send(12'h5a5, 1'b0, 1'b0);
        check("gap_busy3", 32'(busy), 32'd1);
        check("gap_hold_cnt", 32'(count), 32'd1);
        send(12'h000, 1'b1, 1'b0);
        wait_done("gaps");

        // Zero length goes straight to DONE
        push_exp(12'h000, 12'h000, 16'd0);
        do_start(16'd0, 12'h000);
        check("zero_done_next", 32'(done), 32'd1);
        wait_done("zero");

        // start during RUN ignored, including with the final sample
        do_start(16'd3, 12'h000);
        push_exp(fold(fold(fold(12'h000, 12'h111), 12'h222), 12'h333), 12'h000, 16'd3);
        send(12'h111, 1'b1, 1'b1);
        check("ign_busy", 32'(busy), 32'd1);
        send(12'h222, 1'b1, 1'b1);
        send(12'h333, 1'b1, 1'b1);
        wait_done("ignore");

        // Restart from DONE
        do_start(16'd4, 12'h000);
        check("restart_done", 32'(done), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_sig", 32'(sig), 32'h000);
        check("restart_count", 32'(count), 32'd0);
        push_exp(fold(fold(fold(fold(12'h000, 12'hfff), 12'h001), 12'h800), 12'h7ff), 12'h000, 16'd4);
        send(12'hfff, 1'b1, 1'b0);
        send(12'h001, 1'b1, 1'b0);
        send(12'h800, 1'b1, 1'b0);
        send(12'h7ff, 1'b1, 1'b0);
        wait_done("restart");

        for (int i = 0; i < 20; i++) rand_capture(i);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
